// File: rtl/y86_adder_64_if.sv
// Operand/result bundle for the registered 64-bit Y86 ADD path.
interface y86_adder_64_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             cout;

  // Requester side: presents operands, observes results
  modport master (
    output in_valid, a, b,
    input  out_valid, sum, overflow, cout
  );

  // Adder side: consumes operands, returns registered results
  modport slave (
    input  in_valid, a, b,
    output out_valid, sum, overflow, cout
  );
endinterface

// File: rtl/y86_adder_64.sv
// Registered 64-bit two's-complement adder: ripple-carry sum, signed overflow
// and carry-out, captured one clock after the operands with a tracking valid.
module y86_adder_64 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  y86_adder_64_if.slave  bus
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;
  logic             r_cout;

  assign w_a    = bus.a;
  assign w_b    = bus.b;
  assign w_c[0] = 1'b0;

  // One full adder per bit; carry ripples from bit 0 upward
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign w_sum[gi]  = w_a[gi] ^ w_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (w_a[gi] & w_b[gi]) | (w_a[gi] & w_c[gi]) | (w_b[gi] & w_c[gi]);
  end

  // Like-signed operands whose result flips sign have overflowed
  assign w_ovf = (w_a[MSB] == w_b[MSB]) && (w_sum[MSB] != w_a[MSB]);

  // Result capture; data holds when no new operands arrive, valid does not
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum  <= w_sum;
        r_ovf  <= w_ovf;
        r_cout <= w_c[WIDTH];
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.sum       = r_sum;
  assign bus.overflow  = r_ovf;
  assign bus.cout      = r_cout;

endmodule

// File: tb/tb_y86_adder_64.sv
// Directed and random bench for y86_adder_64 with a one-cycle reference model.
module tb_y86_adder_64;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Reference model of the output registers
  logic        m_valid;
  logic [63:0] m_sum;
  logic        m_ovf;
  logic        m_cout;

  y86_adder_64_if #(.WIDTH(64)) bus ();

  y86_adder_64 #(.WIDTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model on the edge, then compare all outputs
  task automatic cycle(input logic r, input logic v, input logic [63:0] x, input logic [63:0] y);
    logic [64:0] t;
    rst_n        = r;
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    t = {1'b0, x} + {1'b0, y};
    if (!r) begin
      m_valid = 1'b0; m_sum = '0; m_ovf = 1'b0; m_cout = 1'b0;
    end else begin
      m_valid = v;
      if (v) begin
        m_sum  = t[63:0];
        m_cout = t[64];
        m_ovf  = (x[63] == y[63]) && (t[63] != x[63]);
      end
    end
    #1;
    chk("model_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("model_sum",   bus.sum,            m_sum);
    chk("model_ovf",   64'(bus.overflow),  64'(m_ovf));
    chk("model_cout",  64'(bus.cout),      64'(m_cout));
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [63:0] s,
                            input logic o, input logic c);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(v));
    chk({tag, "_sum"},   bus.sum,            s);
    chk({tag, "_ovf"},   64'(bus.overflow),  64'(o));
    chk({tag, "_cout"},  64'(bus.cout),      64'(c));
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rv;
    total = 0;
    bad   = 0;
    m_valid = 1'b0; m_sum = '0; m_ovf = 1'b0; m_cout = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;

    // Reset wins over valid operands
    cycle(1'b0, 1'b1, 64'd5, 64'd5);
    expect_out("reset0", 1'b0, 64'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'd5, 64'd5);
    expect_out("reset1", 1'b0, 64'd0, 1'b0, 1'b0);

    // First result one cycle after release
    cycle(1'b1, 1'b1, 64'd5, 64'd5);
    expect_out("first", 1'b1, 64'd10, 1'b0, 1'b0);

    // Basic
    cycle(1'b1, 1'b1, 64'd0, 64'd0);
    expect_out("zero", 1'b1, 64'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h0000_0000_0000_C350, 64'h0000_0000_0000_C350);
    expect_out("basic", 1'b1, 64'h0000_0000_0001_86A0, 1'b0, 1'b0);

    // Overflow boundaries
    cycle(1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    expect_out("pos_ovf", 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    expect_out("neg_ovf", 1'b1, 64'd0, 1'b1, 1'b1);

    // Mixed sign
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    expect_out("m1_p1", 1'b1, 64'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd40);
    expect_out("m100_p40", 1'b1, 64'hFFFF_FFFF_FFFF_FFC4, 1'b0, 1'b0);

    // Back-to-back then hold
    cycle(1'b1, 1'b1, 64'd1, 64'd2);
    expect_out("b2b0", 1'b1, 64'd3, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_out("b2b1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111);
    expect_out("b2b2", 1'b1, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'd7);
    expect_out("hold0", 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 64'd9, 64'd9);
    expect_out("hold1", 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0);

    // Random with a mid-run reset pulse
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        1: rb = 64'h8000_0000_0000_0000;
        2: rb = ~ra + 64'd1;
        default: ;
      endcase
      rv = ($urandom_range(0, 9) != 0);
      if (i == 5000) begin
        cycle(1'b0, 1'b1, ra, rb);
        expect_out("mid_reset", 1'b0, 64'd0, 1'b0, 1'b0);
      end else begin
        cycle(1'b1, rv, ra, rb);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
